mem_alu_sequencer: RTL and testbench
====================================

MEM_ALU_SEQUENCER -- requirements
Module: mem_alu_sequencer

Interface
REQ-001 SHALL have parameter DW, 16, data width in bits (DW >= 16; instruction occupies bits [15:0]).
REQ-002 SHALL have parameter AW, 5, SRAM address width.
REQ-003 SHALL have parameter RW, 4, register-file index width.
REQ-004 SHALL have parameter N_LOAD, 6, data words loaded per run (>= 0).
REQ-005 SHALL have parameter N_INSTR, 3, instruction words loaded and executed per run (>= 1; N_LOAD+N_INSTR <= 2**RW).
REQ-006 SHALL have port clk  in  1  clock; reset is asynchronous, active-high; clock clk.
REQ-007 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports start in 1 (run request, level-sampled in IDLE) and abort in 1 (synchronous run cancel).
REQ-009 SHALL have port sram_base  in  AW  first SRAM address of the run, captured at start acceptance.
REQ-010 SHALL have ports busy out 1, done out 1 (one-cycle pulse), aborted out 1 (one-cycle pulse), carry_any out 1 (sticky OR of alu_cout over the run).
REQ-011 SHALL have SRAM ports ss_cs_n, ss_oe_n, ss_we_n out 1 (active-low), ss_addr out AW, ss_rdata in DW (one-cycle read latency).
REQ-012 SHALL have register-file ports rf_we_n out 1 (active-low), rf_id out RW, rf_wdata out DW, rf_rdata in DW (valid the cycle after rf_id is driven).
REQ-013 SHALL have ALU ports alu_a out DW, alu_b out DW, alu_op out 3, alu_en_n out 1 (active-low), alu_out in DW, alu_cout in 1 (combinational).

Function
REQ-014 SHALL implement states IDLE, LD_RD, LD_WR, LD_NEXT, EX_FETCH, EX_RA, EX_RB, EX_ALU, EX_WB, DONE.
REQ-015 In IDLE with start=1 SHALL capture sram_base, clear carry_any, zero word/instruction counters, go to LD_RD; start in any other state SHALL be ignored.
REQ-016 Load phase: word k (0..N_LOAD+N_INSTR-1) read from SRAM address (sram_base+k) mod 2**AW, written to register k; LD_RD drives ss_cs_n=0, ss_oe_n=0; LD_WR drives rf_we_n=0, rf_wdata=ss_rdata; LD_NEXT deasserts strobes and increments k, 3 cycles/word.
REQ-017 ss_we_n SHALL remain 1 always (block never writes SRAM).
REQ-018 Instruction format: [15] imm, [14:12] op, [11:8] dst, [7:4] srcA, [3:0] srcB or imm4; indices above 2**RW-1 SHALL be truncated to RW bits.
REQ-019 Execute phase, instruction j: EX_FETCH rf_id=N_LOAD+j; EX_RA latch instruction, rf_id=srcA; EX_RB alu_a=rf_rdata, rf_id=srcB; EX_ALU alu_b=imm ? zero-extended imm4 : rf_rdata, alu_op=op, alu_en_n=0, latch alu_out, OR alu_cout into carry_any; EX_WB rf_we_n=0, rf_id=dst, rf_wdata=latched result; 5 cycles/instruction.
REQ-020 Each instruction SHALL be fetched from the register file at execution time; writes to a later instruction register SHALL take effect.
REQ-021 After instruction N_INSTR-1 SHALL enter DONE: done=1 one cycle, then IDLE; done SHALL be high in cycle 3*(N_LOAD+N_INSTR)+5*N_INSTR+1 after the start-acceptance edge (43 at defaults).
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 abort=1 in any non-IDLE state SHALL, next edge, deassert all strobes, pulse aborted, return to IDLE, suppress done; abort in IDLE ignored; abort and final EX_WB in the same cycle: write completes, aborted wins, no done.
REQ-024 carry_any SHALL hold its value in IDLE until next start acceptance.

Reset
REQ-025 reset SHALL asynchronously force IDLE, busy=0, done=0, aborted=0, carry_any=0, ss_cs_n=ss_oe_n=ss_we_n=1, rf_we_n=1, alu_en_n=1, all address/data/op outputs 0, counters 0, including mid-run.

Structure
REQ-026 State enum, instruction field positions, opcode width SHALL live in shared package mem_seq_pkg.
REQ-027 Instruction field extraction and operand-B select SHALL be sub-module mem_seq_decode; rest stays in one module.

Verification
REQ-028 Defaults, SRAM[0..8]=1,2,3,4,5,6,0x0901,0x0A23,0x8B45, ALU op0=ADD -> R9=3, R10=7, R11=10, done at cycle 43, carry_any=0.
REQ-029 sram_base=30 -> ss_addr sequence 30,31,0,1,...,6; registers 0..8 loaded in order.
REQ-030 start held high through run -> exactly one run, start pulses while busy ignored, second run begins only from IDLE.
REQ-031 abort asserted in EX_RB of instruction 1 -> aborted pulse, no further rf_we_n=0, done never asserted, busy=0 next cycle.
REQ-032 reset asserted in LD_WR of word 3 -> all outputs at reset values immediately, no register write that cycle.
REQ-033 R0=0xFFFF, R1=1, instruction 0x0901 -> R9=0, carry_any=1 held until next start.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory/ALU sequencer: controller states and
// instruction word layout.
package mem_seq_pkg;

  // Instruction word layout: [15] imm, [14:12] op, [11:8] dst, [7:4] srcA, [3:0] srcB/imm4
  localparam int INSTR_W  = 16;
  localparam int OP_W     = 3;
  localparam int FIELD_W  = 4;
  localparam int IMM_BIT  = 15;
  localparam int OP_LSB   = 12;
  localparam int DST_LSB  = 8;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_LSB = 0;

  typedef enum logic [3:0] {
    IDLE,
    LD_RD,
    LD_WR,
    LD_NEXT,
    EX_FETCH,
    EX_RA,
    EX_RB,
    EX_ALU,
    EX_WB,
    DONE
  } state_t;

endpackage

// File: rtl/mem_seq_decode.sv
// Instruction field extraction and ALU operand-B selection.
// Register indices are resized to RW bits (truncated when RW < 4).
module mem_seq_decode import mem_seq_pkg::*; #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [DW-1:0]      i_rdata,
  output logic [RW-1:0]      o_dst,
  output logic [RW-1:0]      o_src_a,
  output logic [RW-1:0]      o_src_b,
  output logic [OP_W-1:0]    o_op,
  output logic [DW-1:0]      o_opnd_b
);

  logic w_imm;

  assign w_imm    = i_instr[IMM_BIT];
  assign o_op     = i_instr[OP_LSB +: OP_W];
  assign o_dst    = RW'(i_instr[DST_LSB +: FIELD_W]);
  assign o_src_a  = RW'(i_instr[SRCA_LSB +: FIELD_W]);
  assign o_src_b  = RW'(i_instr[SRCB_LSB +: FIELD_W]);
  // Immediate form uses the zero-extended low nibble in place of R[srcB]
  assign o_opnd_b = w_imm ? DW'(i_instr[SRCB_LSB +: FIELD_W]) : i_rdata;

endmodule

// File: rtl/mem_alu_sequencer.sv
// Sequencer that copies a block of SRAM words into the register file, then
// executes the trailing words as ALU instructions fetched from the register
// file at execution time. Strobes and addresses are decoded from the state.
module mem_alu_sequencer import mem_seq_pkg::*; #(
  parameter int DW      = 16,
  parameter int AW      = 5,
  parameter int RW      = 4,
  parameter int N_LOAD  = 6,
  parameter int N_INSTR = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   sram_base,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            carry_any,
  output logic            ss_cs_n,
  output logic            ss_oe_n,
  output logic            ss_we_n,
  output logic [AW-1:0]   ss_addr,
  input  logic [DW-1:0]   ss_rdata,
  output logic            rf_we_n,
  output logic [RW-1:0]   rf_id,
  output logic [DW-1:0]   rf_wdata,
  input  logic [DW-1:0]   rf_rdata,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic            alu_en_n,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_cout
);

  localparam int N_WORDS = N_LOAD + N_INSTR;
  localparam int CW      = RW + 1;

  state_t               r_state, w_next;
  logic [AW-1:0]        r_base;
  logic [CW-1:0]        r_k, r_j;
  logic [INSTR_W-1:0]   r_instr;
  logic [DW-1:0]        r_a, r_res;
  logic                 r_carry, r_aborted;

  logic [INSTR_W-1:0]   w_instr;
  logic [RW-1:0]        w_dst, w_src_a, w_src_b;
  logic [OP_W-1:0]      w_op;
  logic [DW-1:0]        w_opnd_b;
  logic                 w_last_word, w_last_instr;

  assign w_last_word  = (r_k == CW'(N_WORDS - 1));
  assign w_last_instr = (r_j == CW'(N_INSTR - 1));
  // In EX_RA the instruction is still on rf_rdata; afterwards use the latched copy
  assign w_instr      = (r_state == EX_RA) ? rf_rdata[INSTR_W-1:0] : r_instr;
  assign carry_any    = r_carry;
  assign aborted      = r_aborted;

  mem_seq_decode #(.DW(DW), .RW(RW)) u_decode (
    .i_instr  (w_instr),
    .i_rdata  (rf_rdata),
    .o_dst    (w_dst),
    .o_src_a  (w_src_a),
    .o_src_b  (w_src_b),
    .o_op     (w_op),
    .o_opnd_b (w_opnd_b)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state selection and per-state strobe/address/data decode
  always_comb begin
    w_next   = r_state;
    busy     = (r_state != IDLE);
    done     = 1'b0;
    ss_cs_n  = 1'b1;
    ss_oe_n  = 1'b1;
    ss_we_n  = 1'b1;
    ss_addr  = '0;
    rf_we_n  = 1'b1;
    rf_id    = '0;
    rf_wdata = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_en_n = 1'b1;
    case (r_state)
      IDLE:     if (start) w_next = LD_RD;
      LD_RD: begin
        ss_cs_n = 1'b0;
        ss_oe_n = 1'b0;
        ss_addr = r_base + AW'(r_k);
        w_next  = LD_WR;
      end
      LD_WR: begin
        rf_we_n  = 1'b0;
        rf_id    = RW'(r_k);
        rf_wdata = ss_rdata;
        w_next   = LD_NEXT;
      end
      LD_NEXT:  w_next = w_last_word ? EX_FETCH : LD_RD;
      EX_FETCH: begin
        rf_id  = RW'(CW'(N_LOAD) + r_j);
        w_next = EX_RA;
      end
      EX_RA: begin
        rf_id  = w_src_a;
        w_next = EX_RB;
      end
      EX_RB: begin
        alu_a  = rf_rdata;
        rf_id  = w_src_b;
        w_next = EX_ALU;
      end
      EX_ALU: begin
        alu_a    = r_a;
        alu_b    = w_opnd_b;
        alu_op   = w_op;
        alu_en_n = 1'b0;
        w_next   = EX_WB;
      end
      EX_WB: begin
        rf_we_n  = 1'b0;
        rf_id    = w_dst;
        rf_wdata = r_res;
        w_next   = w_last_instr ? DONE : EX_FETCH;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default:  w_next = IDLE;
    endcase
    // Cancel wins over every transition, including the final write-back
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  // Run context: base, counters, latched instruction/operands and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base    <= '0;
      r_k       <= '0;
      r_j       <= '0;
      r_instr   <= '0;
      r_a       <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= abort && (r_state != IDLE);
      case (r_state)
        IDLE: if (start) begin
          r_base  <= sram_base;
          r_carry <= 1'b0;
          r_k     <= '0;
          r_j     <= '0;
        end
        LD_NEXT: r_k <= r_k + CW'(1);
        EX_RA:   r_instr <= rf_rdata[INSTR_W-1:0];
        EX_RB:   r_a <= rf_rdata;
        EX_ALU: begin
          r_res   <= alu_out;
          r_carry <= r_carry | alu_cout;
        end
        EX_WB:   r_j <= r_j + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_alu_sequencer.sv
// Bench for mem_alu_sequencer: SRAM, register file and ALU models around the
// DUT, a table of directed runs, hand-written abort/reset/start sequences and
// randomized runs checked against an instruction-level reference model.
module tb_mem_alu_sequencer;

  localparam int DW       = 16;
  localparam int AW       = 5;
  localparam int RW       = 4;
  localparam int N_LOAD   = 6;
  localparam int N_INSTR  = 3;
  localparam int NW       = N_LOAD + N_INSTR;
  localparam int DEPTH    = 1 << AW;
  localparam int EXP_DONE = 3 * NW + 5 * N_INSTR + 1;

  typedef logic [DW-1:0] img_t [NW];
  typedef logic [DW-1:0] rf_t [16];
  typedef struct {
    logic [AW-1:0] base;
    logic [DW-1:0] d0, d1;
    logic [15:0]   i0, i1, i2;
    logic [RW-1:0] id0, id1, id2;
    logic [DW-1:0] v0, v1, v2;
    logic          c;
  } vec_t;

  logic          clk, reset, start, abort;
  logic [AW-1:0] sram_base;
  logic          busy, done, aborted, carry_any;
  logic          ss_cs_n, ss_oe_n, ss_we_n;
  logic [AW-1:0] ss_addr;
  logic [DW-1:0] ss_rdata;
  logic          rf_we_n;
  logic [RW-1:0] rf_id;
  logic [DW-1:0] rf_wdata, rf_rdata;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [2:0]    alu_op;
  logic          alu_en_n, alu_cout;

  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] rf [16];
  logic          rf_init;

  int errors = 0, checks = 0;
  int done_cnt = 0, abort_cnt = 0, wr_cnt = 0, we_low_cnt = 0;
  int addr_log[$];

  vec_t          vt[4];
  img_t          img;
  rf_t           pre, post;
  logic          exp_c;
  logic [DW-1:0] pre3;
  int            cyc, w0, dc0, ac0, a0;

  mem_alu_sequencer #(.DW(DW), .AW(AW), .RW(RW), .N_LOAD(N_LOAD), .N_INSTR(N_INSTR)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .sram_base(sram_base),
    .busy(busy), .done(done), .aborted(aborted), .carry_any(carry_any),
    .ss_cs_n(ss_cs_n), .ss_oe_n(ss_oe_n), .ss_we_n(ss_we_n), .ss_addr(ss_addr),
    .ss_rdata(ss_rdata), .rf_we_n(rf_we_n), .rf_id(rf_id), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_en_n(alu_en_n), .alu_out(alu_out), .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a};
      3'd6:    return {1'b0, b};
      default: return {a, 1'b0};
    endcase
  endfunction

  // External component models
  always @(posedge clk) if (!ss_cs_n && !ss_oe_n) ss_rdata <= sram[ss_addr];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= DW'(i * 37 + 5);
    end else if (!rf_we_n) begin
      rf[rf_id] <= rf_wdata;
    end
    rf_rdata <= rf[rf_id];
  end

  always_comb {alu_cout, alu_out} = alu_fn(alu_op, alu_a, alu_b);

  // Event monitors (mid-cycle)
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (aborted === 1'b1) abort_cnt++;
    if (rf_we_n === 1'b0) wr_cnt++;
    if (ss_we_n !== 1'b1) we_low_cnt++;
    if (ss_cs_n === 1'b0 && ss_oe_n === 1'b0) addr_log.push_back(int'(ss_addr));
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {busy, done, aborted, carry_any, ss_cs_n, ss_oe_n, ss_we_n, rf_we_n, alu_en_n,
               ss_addr, rf_id, rf_wdata, alu_a, alu_b, alu_op},
        {4'b0000, 5'b11111, (AW + RW + 3 * DW + 3)'(0)});
  endtask

  // Sequential interpretation of a run: copy words, then run each instruction
  task automatic ref_run(input img_t im, input rf_t r0, output rf_t r1, output logic c);
    logic [15:0]   ins;
    logic [DW-1:0] a, b;
    logic [DW:0]   r;
    r1 = r0;
    c = 1'b0;
    for (int k = 0; k < NW; k++) r1[k] = im[k];
    for (int j = 0; j < N_INSTR; j++) begin
      ins = r1[N_LOAD + j][15:0];
      a = r1[ins[7:4]];
      b = ins[15] ? DW'(ins[3:0]) : r1[ins[3:0]];
      r = alu_fn(ins[14:12], a, b);
      r1[ins[11:8]] = r[DW-1:0];
      c = c | r[DW];
    end
  endtask

  task automatic vec_img(input vec_t v, output img_t im);
    im[0] = v.d0; im[1] = v.d1;
    im[2] = 16'd3; im[3] = 16'd4; im[4] = 16'd5; im[5] = 16'd6;
    im[6] = v.i0; im[7] = v.i1; im[8] = v.i2;
  endtask

  task automatic load_sram(input logic [AW-1:0] base, input img_t im);
    for (int k = 0; k < NW; k++) sram[(int'(base) + k) % DEPTH] = im[k];
  endtask

  task automatic start_run(input logic [AW-1:0] base);
    @(negedge clk);
    sram_base = base;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int c_out);
    c_out = -1;
    for (int c = first; c <= 200; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        c_out = c;
        break;
      end
    end
  endtask

  task automatic full_run(input logic [AW-1:0] base, input img_t im, output int c_out);
    int s0;
    load_sram(base, im);
    s0 = addr_log.size();
    start_run(base);
    @(negedge clk);
    chk("carry_clear_at_start", carry_any, 1'b0);
    wait_done(2, c_out);
    chk("load_addr_count", addr_log.size() - s0, NW);
    for (int k = 0; k < NW && s0 + k < addr_log.size(); k++)
      chk($sformatf("load_addr_%0d", k), addr_log[s0 + k], (int'(base) + k) % DEPTH);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sram_base = '0; rf_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    vt[0] = '{5'd0,  16'd1,      16'd2, 16'h0901, 16'h0A23, 16'h8B45, 4'd9, 4'd10, 4'd11, 16'd3, 16'd7, 16'd10, 1'b0};
    vt[1] = '{5'd30, 16'hFFFF,   16'd1, 16'h0901, 16'h0A23, 16'h8B45, 4'd9, 4'd10, 4'd11, 16'd0, 16'd7, 16'd10, 1'b1};
    vt[2] = '{5'd7,  16'd5,      16'd3, 16'h1901, 16'h2A23, 16'hCB4F, 4'd9, 4'd10, 4'd11, 16'd2, 16'd0, 16'hA,  1'b0};
    vt[3] = '{5'd20, 16'd1,      16'd2, 16'h8870, 16'h0001, 16'h8B45, 4'd0, 4'd8,  4'd7,  16'd5, 16'd1, 16'd1,  1'b0};

    repeat (2) @(negedge clk);
    chk_reset_outs("reset_outputs");
    rf_init = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      vec_img(vt[i], img);
      full_run(vt[i].base, img, cyc);
      chk($sformatf("vec%0d_done_cycle", i), cyc, EXP_DONE);
      chk($sformatf("vec%0d_r%0d", i, vt[i].id0), rf[vt[i].id0], vt[i].v0);
      chk($sformatf("vec%0d_r%0d", i, vt[i].id1), rf[vt[i].id1], vt[i].v1);
      chk($sformatf("vec%0d_r%0d", i, vt[i].id2), rf[vt[i].id2], vt[i].v2);
      chk($sformatf("vec%0d_carry", i), carry_any, vt[i].c);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_carry_held_idle", i), carry_any, vt[i].c);
    end

    // Start held high for the whole run: one run only
    vec_img(vt[0], img);
    load_sram(5'd0, img);
    dc0 = done_cnt; a0 = addr_log.size();
    @(negedge clk);
    sram_base = '0;
    start = 1'b1;
    wait_done(1, cyc);
    start = 1'b0;
    chk("held_start_done_cycle", cyc, EXP_DONE);
    repeat (20) @(negedge clk);
    chk("held_start_done_count", done_cnt - dc0, 1);
    chk("held_start_load_count", addr_log.size() - a0, NW);
    chk("held_start_idle", busy, 1'b0);

    // Abort in EX_RB of instruction 1
    start_run(5'd0);
    repeat (35) @(negedge clk);
    w0 = wr_cnt; dc0 = done_cnt; ac0 = abort_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rb_pulse", aborted, 1'b1);
    chk("abort_rb_busy", busy, 1'b0);
    @(negedge clk);
    chk("abort_rb_pulse_width", aborted, 1'b0);
    repeat (50) @(negedge clk);
    chk("abort_rb_no_writes", wr_cnt - w0, 0);
    chk("abort_rb_no_done", done_cnt - dc0, 0);
    chk("abort_rb_pulse_count", abort_cnt - ac0, 1);

    // Abort together with the final write-back
    img[0] = 16'd7; img[1] = 16'd2; img[8] = 16'h8B05;
    load_sram(5'd0, img);
    dc0 = done_cnt;
    start_run(5'd0);
    repeat (42) @(negedge clk);
    chk("final_wb_strobe", {rf_we_n, rf_id}, {1'b0, 4'd11});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("final_wb_aborted", aborted, 1'b1);
    chk("final_wb_no_done", done, 1'b0);
    chk("final_wb_write_done", rf[11], 16'd12);
    repeat (5) @(negedge clk);
    chk("final_wb_done_count", done_cnt - dc0, 0);

    // Randomized runs against the reference model
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] b;
      b = AW'($urandom_range(0, DEPTH - 1));
      for (int k = 0; k < NW; k++) img[k] = DW'($urandom);
      for (int i = 0; i < 16; i++) pre[i] = rf[i];
      ref_run(img, pre, post, exp_c);
      full_run(b, img, cyc);
      chk($sformatf("rand%0d_done_cycle", r), cyc, EXP_DONE);
      chk($sformatf("rand%0d_carry", r), carry_any, exp_c);
      for (int i = 0; i < 16; i++) chk($sformatf("rand%0d_r%0d", r, i), rf[i], post[i]);
    end

    // Reset during LD_WR of word 3
    vec_img(vt[0], img);
    img[3] = ~rf[3];
    load_sram(5'd0, img);
    start_run(5'd0);
    repeat (11) @(negedge clk);
    chk("ldwr3_strobe", {rf_we_n, rf_id, rf_wdata}, {1'b0, 4'd3, img[3]});
    pre3 = rf[3];
    reset = 1'b1;
    #1;
    chk_reset_outs("midrun_reset_outputs");
    @(posedge clk);
    #1;
    chk("midrun_reset_no_write", rf[3], pre3);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_reset_idle", busy, 1'b0);

    chk("sram_never_written", we_low_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
